i2s_output_stage: RTL and testbench

Output stage directly downstream of the voice mixer. It takes the mixer's 32-bit signed mixed sample and valid pulse, then applies a master gain. It saturates the result to OUT_WIDTH bits, holds it in a single-entry buffer, and serializes it as standard I2S (mono, duplicated to both channels) towards the audio DAC.

---
 rtl/i2s_output_stage.sv | 133 +++++++++++++
 tb/tb_i2s_output_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_output_stage.sv
// Master gain (2-cycle pipe), saturation to OUT_WIDTH, one-entry pending buffer, mono I2S serializer.
// No backpressure: a late sample overwrites the buffer (overrun), a missing one replays the last frame (underrun).
module i2s_output_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 24,
  parameter int GAIN_WIDTH = 16,
  parameter int BCLK_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] mixed_in,
  input  logic                  data_in_valid,
  input  logic [GAIN_WIDTH-1:0] master_gain,
  input  logic                  status_clr,
  output logic                  i2s_bclk,
  output logic                  i2s_lrclk,
  output logic                  i2s_sdata,
  output logic                  overrun,
  output logic                  underrun
);

  localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam int SH = 15 + DATA_WIDTH - OUT_WIDTH;
  localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(BCLK_DIV - 1);
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

  logic                  s1_vld;
  logic signed [PW-1:0]  s1_prod;
  logic signed [PW-1:0]  mixed_ext;
  logic signed [PW-1:0]  gain_ext;
  logic signed [PW-1:0]  shifted;
  logic [OUT_WIDTH-1:0]  sat_val;
  logic [OUT_WIDTH-1:0]  pending;
  logic [OUT_WIDTH-1:0]  frame;
  logic                  pending_valid;
  logic [CW-1:0]         div_cnt;
  logic [5:0]            slot;
  logic [5:0]            slot_next;
  logic                  fall_evt;
  logic                  load;
  logic                  ovr_set;
  logic                  unr_set;
  logic                  sdata_next;

  assign mixed_ext = {{(PW-DATA_WIDTH){mixed_in[DATA_WIDTH-1]}}, mixed_in};
  assign gain_ext  = {{(PW-GAIN_WIDTH){1'b0}}, master_gain};

  always_comb begin
    shifted = s1_prod >>> SH;
    if (shifted > SAT_MAX)
      sat_val = SAT_MAX[OUT_WIDTH-1:0];
    else if (shifted < SAT_MIN)
      sat_val = SAT_MIN[OUT_WIDTH-1:0];
    else
      sat_val = shifted[OUT_WIDTH-1:0];

    fall_evt  = enable && (div_cnt == DIV_LAST) && i2s_bclk;
    slot_next = slot + 6'd1;
    load      = fall_evt && (slot == 6'd63);
    // A load in the same cycle consumes the old entry, so the new write is not an overrun.
    ovr_set   = s1_vld && pending_valid && !load;
    unr_set   = load && !pending_valid;

    // Slot k (1..OUT_WIDTH within each half) carries frame[OUT_WIDTH-k].
    sdata_next = 1'b0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      if (slot_next[4:0] == 5'(OUT_WIDTH - i))
        sdata_next = frame[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld  <= 1'b0;
      s1_prod <= '0;
    end else begin
      s1_vld <= data_in_valid;
      if (data_in_valid)
        s1_prod <= mixed_ext * gain_ext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending       <= '0;
      pending_valid <= 1'b0;
      frame         <= '0;
      overrun       <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      if (load && pending_valid)
        frame <= pending;
      if (s1_vld) begin
        pending       <= sat_val;
        pending_valid <= 1'b1;
      end else if (load) begin
        pending_valid <= 1'b0;
      end
      overrun  <= ovr_set | (overrun & ~status_clr);
      underrun <= unr_set | (underrun & ~status_clr);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt   <= '0;
      i2s_bclk  <= 1'b0;
      slot      <= '0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
    end else if (!enable) begin
      div_cnt   <= '0;
      i2s_bclk  <= 1'b0;
      slot      <= '0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt  <= '0;
      i2s_bclk <= ~i2s_bclk;
      if (i2s_bclk) begin
        slot      <= slot_next;
        i2s_lrclk <= slot_next[5];
        i2s_sdata <= sdata_next;
      end
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_i2s_output_stage.sv
// Randomized bench for i2s_output_stage: a sample-level model predicts each frame's word and the sticky flags.
module tb_i2s_output_stage;
  localparam int D  = 4;
  localparam int FR = 128 * D;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] mixed_in;
  logic        data_in_valid;
  logic [15:0] master_gain;
  logic        status_clr;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        overrun;
  logic        underrun;

  i2s_output_stage #(.DATA_WIDTH(32), .OUT_WIDTH(24), .GAIN_WIDTH(16), .BCLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mixed_in(mixed_in),
    .data_in_valid(data_in_valid), .master_gain(master_gain), .status_clr(status_clr),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
    .overrun(overrun), .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          at;
    logic [23:0] val;
  } pend_t;

  pend_t       pend_q[$];
  logic [23:0] frame_q[$];
  int          n;
  bit          run;
  int          total;
  int          bad;
  logic        m_ovr;
  logic        m_unr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  // Gain, floor-divide by 2^23, clamp to 24-bit signed.
  function automatic logic [23:0] ref_gain(input logic [31:0] m, input logic [15:0] g);
    longint p, d, q;
    p = longint'($signed(m)) * longint'(g);
    d = 64'sd8388608;
    if (p >= 0) q = p / d;
    else        q = -((-p + d - 1) / d);
    if (q > 64'sd8388607)  q = 64'sd8388607;
    if (q < -64'sd8388608) q = -64'sd8388608;
    return q[23:0];
  endfunction

  // Reference model: per clock edge, frame load at every 128*D cycles, pending writes 2 cycles after the strobe.
  initial begin : model
    bit          started, pv, load, so, su;
    logic [23:0] pval, cur;
    pend_t       e;
    n = 0;
    started = 0;
    forever begin
      @(posedge clk);
      if (!run) begin
        n = 0; started = 0; pv = 0; pval = '0; cur = '0;
        m_ovr = 1'b0; m_unr = 1'b0;
        pend_q.delete();
      end else begin
        if (!started) begin
          frame_q.push_back(24'h0);
          started = 1;
        end
        n++;
        load = (n % FR) == 0;
        so = 0; su = 0;
        if (load) begin
          if (pv) begin cur = pval; pv = 0; end
          else su = 1;
          frame_q.push_back(cur);
        end
        if (pend_q.size() > 0 && pend_q[0].at == n) begin
          e = pend_q.pop_front();
          if (pv) so = 1;
          pval = e.val;
          pv = 1;
        end
        m_ovr = so ? 1'b1 : (status_clr ? 1'b0 : m_ovr);
        m_unr = su ? 1'b1 : (status_clr ? 1'b0 : m_unr);
      end
    end
  end

  // Monitor: deserializes each frame at the bench's own bit timing and pops the expected word.
  initial begin : monitor
    logic [23:0] lw, rw, ef;
    bit          junk;
    int          ph, slot, k;
    lw = '0; rw = '0; junk = 0;
    forever begin
      @(negedge clk);
      if (!run) begin
        lw = '0; rw = '0; junk = 0;
        frame_q.delete();
      end else if (n > 0) begin
        ph = n % (2 * D);
        if (ph == D) begin
          check("bclk_high", 32'(i2s_bclk), 32'd1);
        end else if (ph == 0) begin
          slot = (n / (2 * D)) % 64;
          check("bclk_low", 32'(i2s_bclk), 32'd0);
          check("lrclk", 32'(i2s_lrclk), 32'(slot >= 32));
          check("overrun", 32'(overrun), 32'(m_ovr));
          check("underrun", 32'(underrun), 32'(m_unr));
          if (slot == 0) begin
            if (frame_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL frame_q: got empty expected one entry (cycle %0d)", n);
            end else begin
              ef = frame_q.pop_front();
              check("left_word", 32'(lw), 32'(ef));
              check("right_word", 32'(rw), 32'(ef));
              check("idle_bits", 32'(junk), 32'd0);
            end
            lw = '0; rw = '0; junk = 0;
          end
          k = slot % 32;
          if (k >= 1 && k <= 24) begin
            if (slot < 32) lw = {lw[22:0], i2s_sdata};
            else           rw = {rw[22:0], i2s_sdata};
          end else if (i2s_sdata !== 1'b0) begin
            junk = 1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int t);
    int guard = 0;
    while (n < t && guard < 100000) begin
      step();
      guard++;
    end
  endtask

  task automatic send(input logic [31:0] m, input logic [15:0] g);
    pend_t e;
    data_in_valid = 1'b1;
    mixed_in      = m;
    master_gain   = g;
    e.at  = n + 2;
    e.val = ref_gain(m, g);
    pend_q.push_back(e);
    step();
    data_in_valid = 1'b0;
  endtask

  task automatic clr_pulse();
    status_clr = 1'b1;
    step();
    status_clr = 1'b0;
  endtask

  initial begin : stimulus
    int f;
    total = 0; bad = 0;
    run = 0; rst = 1'b0; enable = 1'b1;
    data_in_valid = 1'b0; mixed_in = '0; master_gain = '0; status_clr = 1'b0;
    repeat (3) step();
    check("reset_outputs", 32'({i2s_bclk, i2s_lrclk, i2s_sdata, overrun, underrun}), 32'd0);
    rst = 1'b1;
    run = 1;

    goto(100);  send(32'h12345600, 16'h8000);
    goto(600);  send(32'h7FFFFFFF, 16'hFFFF);
    goto(1100); send(32'h80000000, 16'hFFFF);
    goto(1600); send(32'hFFFFFF00, 16'h4000);
    goto(2100); send(32'h00000300, 16'h4000);
    goto(3700); clr_pulse();
    goto(4200); send(32'h11111100, 16'h8000);
    goto(4210); send(32'h22222200, 16'h8000);
    goto(4300); clr_pulse();
    goto(4700); send(32'h0ABCDE00, 16'h8000);
    goto(5 * FR * 2 - 2); send(32'h5A5A5A00, 16'h8000);

    goto(5700);
    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(60, 700)) step();
      send($urandom, 16'($urandom));
      if ($urandom_range(0, 3) == 0) clr_pulse();
    end

    f = ((n / FR) + 1) * FR;
    goto(f + 40 * 2 * D + 3);
    #2;
    check("pre_reset_lrclk", 32'(i2s_lrclk), 32'd1);
    run = 0;
    rst = 1'b0;
    #1;
    check("async_reset_outputs", 32'({i2s_bclk, i2s_lrclk, i2s_sdata, overrun, underrun}), 32'd0);
    repeat (5) step();
    rst = 1'b1;
    run = 1;
    goto(40); send(32'hC0FFEE00, 16'h8000);
    goto(2 * FR + 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
